// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;

  // Bits needed to hold a counter saturating at max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Priority pick between fetch and data requests with a saturating starvation
// counter that forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = cnt_width(STARVE_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_accept,
  input  logic          i_req_i,
  input  logic          i_req_d,
  output logic          o_pick_i,
  output logic          o_pick_d,
  output logic [CW-1:0] o_starve_cnt
);

  logic [CW-1:0] r_cnt;
  logic          w_starved;

  assign w_starved    = (r_cnt == CW'(STARVE_MAX));
  assign o_pick_d     = i_accept & i_req_d & ~(i_req_i & w_starved);
  assign o_pick_i     = i_accept & i_req_i & ~o_pick_d;
  assign o_starve_cnt = r_cnt;

  // Only data grants that actually bypass a waiting fetch count as starvation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (o_pick_i) begin
      r_cnt <= '0;
    end else if (o_pick_d) begin
      if (!i_req_i) begin
        r_cnt <= '0;
      end else if (!w_starved) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto one variable-latency memory
// port and routes each completion back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        o_dbg_state,
  output logic [7:0]        o_dbg_starve
);

  // Handshakes: a requester holds *_req and its payload until *_gnt is seen
  // high in the same cycle; the transfer happens on that clock edge. On the
  // memory side the command is held while mem_req is high and completes in
  // the cycle mem_ack is high, which also acts as the next accept point.
  localparam int CW = cnt_width(STARVE_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            w_owner;
  logic              w_busy;
  logic              w_accept;
  logic              w_pick_i;
  logic              w_pick_d;
  logic [CW-1:0]     w_starve_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  assign w_busy   = (r_state != IDLE);
  assign w_accept = !w_busy || mem_ack;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_pick (
    .clk          (clk),
    .reset        (reset),
    .i_accept     (w_accept),
    .i_req_i      (i_req),
    .i_req_d      (d_req),
    .o_pick_i     (w_pick_i),
    .o_pick_d     (w_pick_d),
    .o_starve_cnt (w_starve_cnt)
  );

  always_comb begin
    w_owner = OWN_NONE;
    if (w_pick_d) begin
      w_owner = OWN_D;
    end else if (w_pick_i) begin
      w_owner = OWN_I;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (w_owner)
        OWN_I:   w_state_nxt = BUSY_I;
        OWN_D:   w_state_nxt = BUSY_D;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fetch leaves the store data register alone; only the address and we change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_pick_i) begin
      r_we    <= 1'b0;
      r_addr  <= i_addr;
    end else if (w_pick_d) begin
      r_we    <= d_we;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
    end
  end

  assign i_gnt        = w_pick_i;
  assign d_gnt        = w_pick_d;
  assign i_rvalid     = (r_state == BUSY_I) && mem_ack;
  assign d_rvalid     = (r_state == BUSY_D) && mem_ack;
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign mem_req      = w_busy;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign o_dbg_state  = r_state;
  assign o_dbg_starve = 8'(w_starve_cnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a latency-randomised memory model,
// two requester drivers and a transaction-level reference of the arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    dbg_state;
  logic [7:0]    dbg_starve;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .o_dbg_state(dbg_state), .o_dbg_starve(dbg_starve)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bench state ----------------
  int checks;
  int errors;

  logic [DW-1:0] mem_arr [64];   // memory model contents (written via DUT command)
  logic [DW-1:0] ref_arr [64];   // reference contents (written via bench requests)

  bit mm_busy;
  int mm_cnt, mm_lat, lat_lo, lat_hi;
  bit idle_junk;

  int            ref_owner;      // 0 none, 1 fetch, 2 data
  logic [AW-1:0] ref_addr;
  logic          ref_we;
  logic [DW-1:0] ref_wdata;
  int            ref_starve;

  bit exp_i_gnt, exp_d_gnt, exp_i_rvalid, exp_d_rvalid;
  bit i_pend, i_out, d_pend, d_out;
  int issued, issue_limit;

  logic          obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid, obs_mem_req;
  logic [DW-1:0] obs_i_rdata;

  logic [AW-1:0] i_exp_q[$];
  logic [AW-1:0] d_exp_q[$];
  logic [AW-1:0] sb_tmp;

  // ---------------- driver tasks ----------------
  task automatic ref_init();
    ref_owner = 0; ref_addr = '0; ref_we = 1'b0; ref_wdata = '0; ref_starve = 0;
    mm_busy = 1'b0; i_pend = 0; i_out = 0; d_pend = 0; d_out = 0;
    i_exp_q.delete(); d_exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    ref_init();
  endtask

  // Memory model response for the current cycle, then expected completions.
  task automatic pre_cycle();
    if (mem_req === 1'b1) begin
      if (!mm_busy) begin
        mm_busy = 1'b1; mm_cnt = 0; mm_lat = $urandom_range(lat_hi, lat_lo);
      end
      mm_cnt++;
      if (mm_cnt == mm_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[mem_addr[7:2]];
        if (mem_we === 1'b1) mem_arr[mem_addr[7:2]] = mem_wdata;
        mm_busy   = 1'b0;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
    end else begin
      mm_busy   = 1'b0;
      mem_ack   = idle_junk ? ($urandom_range(3, 0) == 0) : 1'b0;
      mem_rdata = $urandom;
    end
    exp_i_rvalid = (ref_owner == 1) && mem_ack;
    exp_d_rvalid = (ref_owner == 2) && mem_ack;
  endtask

  // Expected grants, sampling and comparison, clock edge, reference update.
  task automatic post_cycle();
    bit            acc;
    logic [DW-1:0] exp_data;
    state_t        exp_st;
    acc       = (ref_owner == 0) || (mem_ack == 1'b1);
    exp_d_gnt = acc && (d_req == 1'b1) && !((i_req == 1'b1) && (ref_starve == SM));
    exp_i_gnt = acc && (i_req == 1'b1) && !exp_d_gnt;
    exp_data  = ref_arr[ref_addr[7:2]];
    exp_st    = (ref_owner == 1) ? BUSY_I : (ref_owner == 2) ? BUSY_D : IDLE;
    #3;
    obs_i_gnt = i_gnt; obs_d_gnt = d_gnt; obs_i_rvalid = i_rvalid; obs_d_rvalid = d_rvalid;
    obs_mem_req = mem_req; obs_i_rdata = i_rdata;
    checks++; if (i_gnt !== exp_i_gnt) begin errors++; $display("FAIL i_gnt @%0t: got %b expected %b", $time, i_gnt, exp_i_gnt); end
    checks++; if (d_gnt !== exp_d_gnt) begin errors++; $display("FAIL d_gnt @%0t: got %b expected %b", $time, d_gnt, exp_d_gnt); end
    checks++; if (i_rvalid !== exp_i_rvalid) begin errors++; $display("FAIL i_rvalid @%0t: got %b expected %b", $time, i_rvalid, exp_i_rvalid); end
    checks++; if (d_rvalid !== exp_d_rvalid) begin errors++; $display("FAIL d_rvalid @%0t: got %b expected %b", $time, d_rvalid, exp_d_rvalid); end
    checks++; if (mem_req !== (ref_owner != 0)) begin errors++; $display("FAIL mem_req @%0t: got %b expected %b", $time, mem_req, (ref_owner != 0)); end
    checks++; if (mem_addr !== ref_addr) begin errors++; $display("FAIL mem_addr @%0t: got %h expected %h", $time, mem_addr, ref_addr); end
    checks++; if (mem_we !== ref_we) begin errors++; $display("FAIL mem_we @%0t: got %b expected %b", $time, mem_we, ref_we); end
    checks++; if (mem_wdata !== ref_wdata) begin errors++; $display("FAIL mem_wdata @%0t: got %h expected %h", $time, mem_wdata, ref_wdata); end
    checks++; if (dbg_state !== exp_st) begin errors++; $display("FAIL state @%0t: got %0d expected %0d", $time, dbg_state, exp_st); end
    checks++; if (dbg_starve !== 8'(ref_starve)) begin errors++; $display("FAIL starve_cnt @%0t: got %0d expected %0d", $time, dbg_starve, ref_starve); end
    if (exp_i_rvalid) begin
      checks++; if (i_rdata !== exp_data) begin errors++; $display("FAIL i_rdata @%0t: got %h expected %h", $time, i_rdata, exp_data); end
    end
    if (exp_d_rvalid && !ref_we) begin
      checks++; if (d_rdata !== exp_data) begin errors++; $display("FAIL d_rdata @%0t: got %h expected %h", $time, d_rdata, exp_data); end
    end
    // scoreboard: each observed grant must be matched by exactly one rvalid
    if (i_rvalid === 1'b1) begin
      checks++;
      if (i_exp_q.size() == 0) begin errors++; $display("FAIL i_orphan_rvalid @%0t: got rvalid expected none", $time); end
      else sb_tmp = i_exp_q.pop_front();
    end
    if (d_rvalid === 1'b1) begin
      checks++;
      if (d_exp_q.size() == 0) begin errors++; $display("FAIL d_orphan_rvalid @%0t: got rvalid expected none", $time); end
      else sb_tmp = d_exp_q.pop_front();
    end
    if (i_gnt === 1'b1) i_exp_q.push_back(i_addr);
    if (d_gnt === 1'b1) d_exp_q.push_back(d_addr);
    if (exp_d_rvalid && ref_we) ref_arr[ref_addr[7:2]] = ref_wdata;
    @(posedge clk); #1;
    if (exp_d_gnt) begin
      ref_owner = 2; ref_addr = d_addr; ref_we = d_we; ref_wdata = d_wdata;
      ref_starve = (i_req == 1'b1) ? ((ref_starve < SM) ? ref_starve + 1 : SM) : 0;
    end else if (exp_i_gnt) begin
      ref_owner = 1; ref_addr = i_addr; ref_we = 1'b0; ref_starve = 0;
    end else if (acc) begin
      ref_owner = 0;
    end
  endtask

  // One full cycle of both requesters; pct_* is the chance of a new request.
  task automatic drive_cycle(input int pct_i, input int pct_d);
    pre_cycle();
    if (i_out && exp_i_rvalid) i_out = 0;
    if (d_out && exp_d_rvalid) d_out = 0;
    if (!i_pend && !i_out && issued < issue_limit && $urandom_range(99, 0) < pct_i) begin
      i_pend = 1; i_addr = 32'($urandom_range(63, 0)) << 2; issued++;
    end else if (!i_pend) begin
      i_addr = $urandom;
    end
    if (!d_pend && !d_out && issued < issue_limit && $urandom_range(99, 0) < pct_d) begin
      d_pend = 1; d_addr = 32'($urandom_range(63, 0)) << 2; d_we = 1'($urandom_range(1, 0));
      d_wdata = $urandom; issued++;
    end else if (!d_pend) begin
      d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1, 0));
    end
    i_req = i_pend; d_req = d_pend;
    post_cycle();
    if (exp_i_gnt) begin i_pend = 0; i_out = 1; end
    if (exp_d_gnt) begin d_pend = 0; d_out = 1; end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((i_pend || d_pend || i_out || d_out) && g < 300) begin
      g++; drive_cycle(0, 0);
    end
    checks++;
    if (i_pend || d_pend || i_out || d_out) begin
      errors++; $display("FAIL drain_timeout: got outstanding after %0d cycles expected idle", g);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    i_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
    @(posedge clk); #3;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if ({i_gnt, d_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", {i_gnt, d_gnt}); end
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b expected 00", {i_rvalid, d_rvalid}); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, IDLE); end
    checks++; if (dbg_starve !== 8'd0) begin errors++; $display("FAIL rst_starve: got %0d expected 0", dbg_starve); end
    do_reset();
  endtask

  task automatic test_fetch_single();
    do_reset();
    lat_lo = 1; lat_hi = 1; idle_junk = 0; issued = 0; issue_limit = 0;
    mem_arr[4] = 32'h00A00093; ref_arr[4] = 32'h00A00093;
    i_pend = 1; i_addr = 32'h10;
    drive_cycle(0, 0);
    checks++; if (obs_i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt_n: got %b expected 1", obs_i_gnt); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL fetch_cmd_n1: got req=%b addr=%h expected req=1 addr=00000010", mem_req, mem_addr);
    end
    drive_cycle(0, 0);
    checks++; if (obs_i_rvalid !== 1'b1 || obs_i_rdata !== 32'h00A00093) begin
      errors++; $display("FAIL fetch_rvalid_n1: got v=%b d=%h expected v=1 d=00a00093", obs_i_rvalid, obs_i_rdata);
    end
    drain();
  endtask

  task automatic test_priority();
    int t, d_g, i_g, d_rv, drops;
    bit i_done;
    do_reset();
    lat_lo = 3; lat_hi = 3; idle_junk = 0; issued = 0; issue_limit = 0;
    i_pend = 1; i_addr = 32'h20;
    d_pend = 1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h0000_DEAD;
    t = 0; d_g = -1; i_g = -1; d_rv = -1; drops = 0; i_done = 0;
    while ((i_pend || d_pend || i_out || d_out) && t < 30) begin
      drive_cycle(0, 0);
      if (obs_d_gnt === 1'b1 && d_g < 0) d_g = t;
      if (obs_i_gnt === 1'b1 && i_g < 0) i_g = t;
      if (obs_d_rvalid === 1'b1 && d_rv < 0) d_rv = t;
      if (t >= 1 && !i_done && obs_mem_req !== 1'b1) drops++;
      if (obs_i_rvalid === 1'b1) i_done = 1;
      if (t == 0) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40) begin
          errors++; $display("FAIL prio_data_cmd: got we=%b addr=%h expected we=1 addr=00000040", mem_we, mem_addr);
        end
      end
      t++;
    end
    checks++; if (d_g != 0) begin errors++; $display("FAIL prio_data_first: got cycle %0d expected 0", d_g); end
    checks++; if (i_g != 3 || d_rv != 3) begin
      errors++; $display("FAIL prio_b2b_grant: got i_gnt@%0d d_rvalid@%0d expected 3 and 3", i_g, d_rv);
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL prio_mem_req_bubble: got %0d drops expected 0", drops); end
    checks++; if (mem_arr[16] !== 32'h0000_DEAD) begin errors++; $display("FAIL prio_store: got %h expected 0000dead", mem_arr[16]); end
    drain();
  endtask

  task automatic test_starvation();
    int d_before, g;
    bit seen_i;
    do_reset();
    lat_lo = 1; lat_hi = 1; idle_junk = 0; issued = 0; issue_limit = 20;
    d_before = 0; g = 0; seen_i = 0;
    while (!seen_i && g < 100) begin
      g++;
      drive_cycle(100, 100);
      if (obs_i_gnt === 1'b1) begin
        seen_i = 1;
        checks++; if (dbg_starve !== 8'd0) begin errors++; $display("FAIL starve_clear: got %0d expected 0", dbg_starve); end
      end else if (obs_d_gnt === 1'b1) begin
        d_before++;
      end
    end
    checks++; if (!seen_i) begin errors++; $display("FAIL starve_timeout: got no fetch grant expected one"); end
    checks++; if (d_before != SM) begin errors++; $display("FAIL starve_count: got %0d data grants expected %0d", d_before, SM); end
    issue_limit = 0;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_lo = 8; lat_hi = 8; idle_junk = 0; issued = 0; issue_limit = 0;
    d_pend = 1; d_we = 1'b1; d_addr = 32'h44; d_wdata = $urandom;
    drive_cycle(0, 0);
    drive_cycle(0, 0);
    drive_cycle(0, 0);
    checks++; if (mem_req !== 1'b1 || dbg_state !== BUSY_D) begin
      errors++; $display("FAIL rstmid_busy: got req=%b st=%0d expected req=1 st=%0d", mem_req, dbg_state, BUSY_D);
    end
    d_req = 1'b0; mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: got %b expected 0", mem_req); end
    mem_ack = 1'b1;
    #1;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %b expected 0", d_rvalid); end
    @(posedge clk); #1;
    reset = 1'b0;
    ref_init();
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      #3;
      checks++; if ({mem_req, i_rvalid, d_rvalid} !== 3'b000 || dbg_state !== IDLE) begin
        errors++; $display("FAIL rstmid_ack_ignored: got req/iv/dv=%b st=%0d expected 000 st=0", {mem_req, i_rvalid, d_rvalid}, dbg_state);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    checks++; if (mem_arr[17] !== ref_arr[17]) begin errors++; $display("FAIL rstmid_store_abandoned: got %h expected %h", mem_arr[17], ref_arr[17]); end
    i_pend = 1; i_addr = 32'h18; lat_lo = 1; lat_hi = 2;
    drain();
  endtask

  task automatic test_random();
    int g;
    do_reset();
    lat_lo = 1; lat_hi = 8; idle_junk = 1; issued = 0; issue_limit = 200;
    g = 0;
    while ((issued < issue_limit || i_pend || d_pend || i_out || d_out) && g < 6000) begin
      g++;
      drive_cycle(45, 55);
    end
    checks++; if (g >= 6000) begin errors++; $display("FAIL random_timeout: got %0d issued expected %0d done", issued, issue_limit); end
    checks++; if (i_exp_q.size() != 0) begin errors++; $display("FAIL i_missing_rvalid: got %0d pending expected 0", i_exp_q.size()); end
    checks++; if (d_exp_q.size() != 0) begin errors++; $display("FAIL d_missing_rvalid: got %0d pending expected 0", d_exp_q.size()); end
    idle_junk = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; errors = 0;
    lat_lo = 1; lat_hi = 1; idle_junk = 0; issued = 0; issue_limit = 0;
    for (int k = 0; k < 64; k++) begin
      mem_arr[k] = $urandom;
      ref_arr[k] = mem_arr[k];
    end
    ref_init();
    test_reset();
    test_fetch_single();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
